// File: rtl/tiamc1_pkg.sv
// Shared types and constants for the TIA-MC1 download/reset sequencer.
package tiamc1_pkg;

  typedef enum logic [1:0] {
    ST_LOCKWAIT = 2'd0,
    ST_LOAD     = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_RUN      = 2'd3
  } dl_state_t;

  typedef enum logic [1:0] {
    BANK_PRG = 2'd0,
    BANK_CHR = 2'd1,
    BANK_PAL = 2'd2
  } bank_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_TNO = 8'd1;

endpackage

// File: rtl/tiamc1_dl_ctrl_if.sv
// ROM bank write port: one pending byte, held until the bank acknowledges it.
interface tiamc1_dl_ctrl_if;
  import tiamc1_pkg::*;

  logic        mem_req;
  bank_t       mem_bank;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;

  modport master (
    output mem_req, mem_bank, mem_addr, mem_data,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_bank, mem_addr, mem_data,
    output mem_ack
  );

endinterface

// File: rtl/tiamc1_dl_decode.sv
// Maps a flat ioctl image address onto a ROM bank and an offset inside it.
module tiamc1_dl_decode
  import tiamc1_pkg::*;
#(
  parameter logic [19:0] BANK1_BASE = 20'h10000,
  parameter logic [19:0] BANK2_BASE = 20'h18000,
  parameter logic [19:0] IMG_END    = 20'h18100
) (
  input  logic [19:0] addr,
  output bank_t       bank,
  output logic [15:0] offset,
  output logic        drop
);

  // Region compare; anything past the image end is flagged for dropping.
  always_comb begin
    bank   = BANK_PRG;
    offset = addr[15:0];
    drop   = 1'b0;
    if (addr < BANK1_BASE) begin
      bank   = BANK_PRG;
      offset = addr[15:0];
    end else if (addr < BANK2_BASE) begin
      bank   = BANK_CHR;
      offset = 16'(addr - BANK1_BASE);
    end else if (addr < IMG_END) begin
      bank   = BANK_PAL;
      offset = 16'(addr - BANK2_BASE);
    end else begin
      drop   = 1'b1;
    end
  end

endmodule

// File: rtl/tiamc1_dl_ctrl.sv
// Download and reset sequencer: holds the core in reset until lock and
// download are done, and turns ioctl bytes into buffered ROM bank writes.
module tiamc1_dl_ctrl
  import tiamc1_pkg::*;
#(
  parameter logic [19:0] BANK1_BASE = 20'h10000,
  parameter logic [19:0] BANK2_BASE = 20'h18000,
  parameter logic [19:0] IMG_END    = 20'h18100,
  parameter int          SETTLE     = 1024
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    clkLocked,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [7:0]              ioctl_index,
  input  logic [19:0]             ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic                    ioctl_wait,
  tiamc1_dl_ctrl_if.master        mem,
  output logic                    core_reset,
  output logic [7:0]              tno,
  output logic                    dl_active,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(SETTLE);

  logic             lock_p0, lock_p1;
  dl_state_t        state, state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic             settle_done;
  logic             core_reset_nxt, dl_active_nxt;
  bank_t            dec_bank;
  logic [15:0]      dec_offset;
  logic             dec_drop;
  logic             rom_byte;

  tiamc1_dl_decode #(
    .BANK1_BASE (BANK1_BASE),
    .BANK2_BASE (BANK2_BASE),
    .IMG_END    (IMG_END)
  ) u_decode (
    .addr   (ioctl_addr),
    .bank   (dec_bank),
    .offset (dec_offset),
    .drop   (dec_drop)
  );

  assign settle_done = (settle_cnt == CNT_W'(SETTLE - 1));
  assign rom_byte    = (state == ST_LOAD) && ioctl_wr && (ioctl_index == IDX_ROM) && !dec_drop;
  assign ioctl_wait  = mem.mem_req;

  // Lock synchroniser: clkLocked comes from the PLL domain, two flops.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= clkLocked;
      lock_p1 <= lock_p0;
    end
  end

  // Sequencer state, settle counter and registered reset/LED outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_LOCKWAIT;
      settle_cnt <= '0;
      core_reset <= 1'b1;
      dl_active  <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= (state == ST_SETTLE && state_nxt == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
      core_reset <= core_reset_nxt;
      dl_active  <= dl_active_nxt;
    end
  end

  // Next state: a ROM download pre-empts everything, lock loss drops back.
  always_comb begin
    state_nxt      = state;
    core_reset_nxt = 1'b1;
    dl_active_nxt  = 1'b0;
    if (ioctl_download && ioctl_index == IDX_ROM) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_LOCKWAIT: if (lock_p1) state_nxt = ST_SETTLE;
        ST_LOAD:     if (!ioctl_download && !mem.mem_req) state_nxt = ST_SETTLE;
        ST_SETTLE: begin
          if (!lock_p1)        state_nxt = ST_LOCKWAIT;
          else if (settle_done) state_nxt = ST_RUN;
        end
        ST_RUN:      if (!lock_p1) state_nxt = ST_LOCKWAIT;
        default:     state_nxt = ST_LOCKWAIT;
      endcase
    end
    core_reset_nxt = (state_nxt != ST_RUN);
    dl_active_nxt  = (state_nxt == ST_LOAD);
  end

  // One-entry write buffer; a byte landing in the ack cycle refills it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem.mem_req  <= 1'b0;
      mem.mem_bank <= BANK_PRG;
      mem.mem_addr <= '0;
      mem.mem_data <= '0;
      overrun      <= 1'b0;
    end else if (rom_byte) begin
      if (mem.mem_req && !mem.mem_ack) begin
        overrun <= 1'b1;
      end else begin
        mem.mem_req  <= 1'b1;
        mem.mem_bank <= dec_bank;
        mem.mem_addr <= dec_offset;
        mem.mem_data <= ioctl_dout;
      end
    end else if (mem.mem_ack) begin
      mem.mem_req <= 1'b0;
    end
  end

  // Title number latch from the index-1 transfer, in any state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tno <= '0;
    end else if (ioctl_wr && ioctl_index == IDX_TNO) begin
      tno <= ioctl_dout;
    end
  end

endmodule

// File: tb/tb_tiamc1_dl_ctrl.sv
// Bench for tiamc1_dl_ctrl: random and directed ioctl traffic, scoreboard on
// the ROM bank write port, reference model of buffer/overrun/title state.
module tb_tiamc1_dl_ctrl;
  import tiamc1_pkg::*;

  localparam int SETTLE_CYC = 4;
  localparam int B1_BASE    = 'h10000;
  localparam int B2_BASE    = 'h18000;
  localparam int END_ADDR   = 'h18100;

  logic        clk_sys = 1'b0;
  logic        reset, clkLocked, ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [19:0] ioctl_addr;
  logic        ioctl_wait, core_reset, dl_active, overrun;
  logic [7:0]  tno;

  always #5 clk_sys = ~clk_sys;

  tiamc1_dl_ctrl_if mem_if();

  tiamc1_dl_ctrl #(
    .BANK1_BASE (20'h10000),
    .BANK2_BASE (20'h18000),
    .IMG_END    (20'h18100),
    .SETTLE     (SETTLE_CYC)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .clkLocked      (clkLocked),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem            (mem_if),
    .core_reset     (core_reset),
    .tno            (tno),
    .dl_active      (dl_active),
    .overrun        (overrun)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_pop = 0;
  bit          m_busy = 0;
  bit          m_ovr = 0;
  logic [7:0]  m_tno = 8'h00;
  bit          loading = 0;
  bit          chk_en = 0;
  logic [25:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rule: flat image address -> {bank, offset, data}; hit=0 if beyond image.
  function automatic void ref_decode(input logic [19:0] a, input logic [7:0] d,
                                     output bit hit, output logic [25:0] e);
    int ai;
    ai  = int'(a);
    hit = 1'b1;
    e   = '0;
    if (ai < B1_BASE)        e = {2'd0, 16'(ai), d};
    else if (ai < B2_BASE)   e = {2'd1, 16'(ai - B1_BASE), d};
    else if (ai < END_ADDR)  e = {2'd2, 16'(ai - B2_BASE), d};
    else                     hit = 1'b0;
  endfunction

  // Reference model: occupancy of the one-byte buffer, overrun, title number.
  always @(posedge clk_sys) begin : model
    bit          hit;
    logic [25:0] e;
    if (reset) begin
      m_busy = 0;
      m_ovr  = 0;
      m_tno  = 8'h00;
      exp_q.delete();
    end else begin
      hit = 0;
      e   = '0;
      if (ioctl_wr && ioctl_index == 8'd1) m_tno = ioctl_dout;
      if (loading && ioctl_wr && ioctl_index == 8'd0) ref_decode(ioctl_addr, ioctl_dout, hit, e);
      if (hit) begin
        if (m_busy && !mem_if.mem_ack) m_ovr = 1;
        else begin
          exp_q.push_back(e);
          m_busy = 1;
        end
      end else if (mem_if.mem_ack) begin
        m_busy = 0;
      end
    end
  end

  // Monitor: compare status against the model, pop a write on every ack.
  always @(negedge clk_sys) begin : monitor
    logic [25:0] e;
    if (chk_en) begin
      chk("mem_req", mem_if.mem_req, m_busy);
      chk("ioctl_wait", ioctl_wait, m_busy);
      chk("overrun", overrun, m_ovr);
      chk("tno", tno, m_tno);
      if (mem_if.mem_req && mem_if.mem_ack) begin
        if (exp_q.size() == 0) begin
          chk("write_expected", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          chk("wr_bank", 32'(mem_if.mem_bank), 32'(e[25:24]));
          chk("wr_addr", mem_if.mem_addr, e[23:8]);
          chk("wr_data", mem_if.mem_data, e[7:0]);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic byte_wr(input logic [7:0] idx, input logic [19:0] a, input logic [7:0] d, input bit ack);
    ioctl_wr       = 1'b1;
    ioctl_index    = idx;
    ioctl_addr     = a;
    ioctl_dout     = d;
    mem_if.mem_ack = ack;
    tick(1);
    ioctl_wr       = 1'b0;
    ioctl_index    = 8'd0;
    mem_if.mem_ack = 1'b0;
  endtask

  task automatic ack_pulse();
    mem_if.mem_ack = 1'b1;
    tick(1);
    mem_if.mem_ack = 1'b0;
  endtask

  task automatic cycles_to_run(output int cnt);
    cnt = 0;
    while (core_reset && cnt < 50) begin
      tick(1);
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    int          p0;
    logic [19:0] strm [4];
    strm[0] = 20'h00000; strm[1] = 20'h10005; strm[2] = 20'h18010; strm[3] = 20'h18100;

    reset = 1'b1; clkLocked = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = '0; mem_if.mem_ack = 1'b0;
    tick(3);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_mem_req", mem_if.mem_req, 0);
    chk("rst_ioctl_wait", ioctl_wait, 0);
    chk("rst_tno", tno, 0);
    chk("rst_dl_active", dl_active, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_mem_bank", 32'(mem_if.mem_bank), 0);
    chk("rst_mem_addr", mem_if.mem_addr, 0);
    chk("rst_mem_data", mem_if.mem_data, 0);
    reset = 1'b0;
    chk_en = 1;
    tick(5);
    chk("no_lock_core_reset", core_reset, 1);

    // PLL lock: 2 sync flops + 1 transition + SETTLE cycles
    clkLocked = 1'b1;
    cycles_to_run(cnt);
    chk("lock_to_run_cycles", cnt, 2 + 1 + SETTLE_CYC);

    // Title number during RUN
    byte_wr(8'd1, 20'h0, 8'h03, 0);
    tick(1);
    chk("tno_run", tno, 8'h03);
    chk("tno_core_reset", core_reset, 0);

    // Enter download
    ioctl_download = 1'b1;
    tick(1);
    chk("load_dl_active", dl_active, 1);
    chk("load_core_reset", core_reset, 1);
    loading = 1;

    // Directed stream with ack one cycle after each strobe
    p0 = n_pop;
    for (int i = 0; i < 4; i++) begin
      byte_wr(8'd0, strm[i], 8'hA0 + 8'(i), 0);
      ack_pulse();
    end
    tick(1);
    chk("stream_write_count", n_pop - p0, 3);

    // Strobe coincident with ack
    byte_wr(8'd0, 20'h00123, 8'h11, 0);
    byte_wr(8'd0, 20'h10200, 8'h22, 1);
    chk("b2b_req", mem_if.mem_req, 1);
    chk("b2b_bank", 32'(mem_if.mem_bank), 1);
    chk("b2b_addr", mem_if.mem_addr, 16'h0200);
    chk("b2b_data", mem_if.mem_data, 8'h22);
    chk("b2b_overrun", overrun, 0);
    ack_pulse();

    // Random traffic, random ack latency, some acks coincident with strobes
    for (int i = 0; i < 80; i++) begin
      logic [19:0] a;
      logic [7:0]  d;
      bit          co;
      case ($urandom_range(0, 3))
        0:       a = 20'($urandom_range(0, 'hFFFF));
        1:       a = 20'($urandom_range('h10000, 'h17FFF));
        2:       a = 20'($urandom_range('h18000, 'h180FF));
        default: a = 20'($urandom_range('h18100, 'hFFFFF));
      endcase
      d  = 8'($urandom);
      co = m_busy && ($urandom_range(0, 1) == 1);
      if (m_busy && !co) begin
        tick($urandom_range(0, 2));
        ack_pulse();
      end
      byte_wr(8'd0, a, d, co);
      if (!m_busy && $urandom_range(0, 3) == 0) ack_pulse();
    end
    if (m_busy) ack_pulse();

    // Held-off ack: wait stays high, second strobe lost, first byte kept
    byte_wr(8'd0, 20'h00042, 8'h5A, 0);
    chk("hold_wait_1", ioctl_wait, 1);
    tick(1);
    chk("hold_wait_2", ioctl_wait, 1);
    byte_wr(8'd0, 20'h00043, 8'hC3, 0);
    chk("hold_overrun", overrun, 1);
    chk("hold_wait_3", ioctl_wait, 1);
    tick(2);
    chk("hold_wait_5", ioctl_wait, 1);
    chk("hold_first_addr", mem_if.mem_addr, 16'h0042);
    chk("hold_first_data", mem_if.mem_data, 8'h5A);
    ack_pulse();
    chk("hold_wait_clear", ioctl_wait, 0);
    tick(1);
    chk("overrun_sticky", overrun, 1);

    // Download end with empty buffer: transition + SETTLE cycles
    ioctl_download = 1'b0;
    cycles_to_run(cnt);
    loading = 0;
    chk("dl_end_to_run_cycles", cnt, 1 + SETTLE_CYC);
    chk("run_dl_active", dl_active, 0);

    // Reset in the middle of a load with a pending write
    ioctl_download = 1'b1;
    tick(1);
    loading = 1;
    byte_wr(8'd0, 20'h18007, 8'h77, 0);
    chk("pre_reset_req", mem_if.mem_req, 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    loading = 0;
    tick(1);
    reset = 1'b0;
    chk("reset_mem_req", mem_if.mem_req, 0);
    chk("reset_core_reset", core_reset, 1);
    chk("reset_dl_active", dl_active, 0);
    chk("reset_overrun", overrun, 0);
    cycles_to_run(cnt);
    chk("relock_cycles_in_range", (cnt >= SETTLE_CYC + 1) && (cnt <= SETTLE_CYC + 3), 1);

    tick(2);
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tiamc1_dl_ctrl.md
# tiamc1_dl_ctrl

Download and reset sequencer for the TIA-MC1 core. It sits between the `hps_io` ioctl port and the core's on-chip ROM banks. It holds the core in reset until the PLL locks and while a ROM image is streaming. It decodes each ioctl byte into a ROM bank write through a one-entry buffered request/acknowledge port, back-pressuring the HPS with `ioctl_wait`. It also latches the title number from index 1, then releases core reset after a settle delay.

## Interface
Parameters:
- `BANK1_BASE`, 20'h10000: first address of bank 1 (character/sprite ROM); bank 0 (program ROM) covers 0..BANK1_BASE-1.
- `BANK2_BASE`, 20'h18000: first address of bank 2 (colour PROM).
- `IMG_END`, 20'h18100: first address past the image; bytes at or above it are dropped.
- `SETTLE`, 1024: clk_sys cycles core reset stays asserted after lock or download end (≥2).

Ports:
- `clk_sys` in 1: system clock, all logic rising edge.
- `reset` in 1: synchronous, active-high.
- `clkLocked` in 1: PLL lock, asynchronous, 2-flop synchronised internally.
- `ioctl_download` in 1: HPS transfer active.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_index` in 8: 0 = ROM image, 1 = title number.
- `ioctl_addr` in 20: byte address.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: HPS stall.
- `mem_req` out 1: bank write pending.
- `mem_bank` out 2: target bank 0..2.
- `mem_addr` out 16: offset within bank.
- `mem_data` out 8: write byte.
- `mem_ack` in 1: bank accepted write this cycle.
- `core_reset` out 1: reset to CPU/video/sound.
- `tno` out 8: title number.
- `dl_active` out 1: drives LED_DISK.
- `overrun` out 1: sticky, strobe lost while buffer full.

## Operation
- States: LOCKWAIT, LOAD, SETTLE, RUN.
- `reset` → LOCKWAIT. Outputs reset to: `core_reset`=1, `mem_req`=0, `ioctl_wait`=0, `tno`=0, `dl_active`=0, `overrun`=0, `mem_bank/addr/data`=0, settle counter=0.
- LOCKWAIT → SETTLE when synchronised lock=1.
- Any state → LOAD when `ioctl_download`=1 and `ioctl_index`=0. Download takes priority over lock and settle.
- LOAD → SETTLE when `ioctl_download` falls and `mem_req`=0. If a write is still pending, stay in LOAD until it is acked.
- SETTLE counts 0..SETTLE-1, then → RUN. Lock loss in SETTLE or RUN → LOCKWAIT.
- `core_reset`=1 in every state except RUN. `dl_active`=1 in LOAD only.
- Byte decode in LOAD, on `ioctl_wr` with index 0:
  - addr < BANK1_BASE → bank 0, offset = addr[15:0].
  - addr < BANK2_BASE → bank 1, offset = addr−BANK1_BASE, truncated to 16 bits.
  - addr < IMG_END → bank 2, offset = addr−BANK2_BASE.
  - Otherwise dropped; no request is raised.
- Buffer: a decoded byte loads bank/addr/data and sets `mem_req`. `mem_ack` while `mem_req` clears it.
  - A strobe arriving in the ack cycle loads the new byte, so `mem_req` stays 1 (back-to-back).
  - A strobe arriving while `mem_req`=1 and no ack is discarded and sets `overrun`. `overrun` clears only on `reset`.
- `ioctl_wait` = `mem_req` (registered, high from the cycle after load until the cycle after ack).
- `ioctl_wr` with index 1 in any state: `tno` ← `ioctl_dout`. This causes no state change and no bank write.
- `mem_ack` while `mem_req`=0 is ignored.

## Timing
- Strobe at cycle n → `mem_req`, `mem_*`, `ioctl_wait` valid at n+1. Ack at m clears them at m+1.
- Download end with empty buffer at n → SETTLE at n+1. `core_reset` falls at n+1+SETTLE.
- Lock rises asynchronously → seen after 2 flops → SETTLE one cycle later.
- `reset` mid-LOAD abandons the pending write (`mem_req`=0 next cycle). The core stays in reset until lock and SETTLE complete.

## Structure
- Shared package `tiamc1_pkg`: state enum `dl_state_t`, bank enum (`BANK_PRG`=0, `BANK_CHR`=1, `BANK_PAL`=2), ioctl index constants `IDX_ROM`=0, `IDX_TNO`=1.
- One sub-module `tiamc1_dl_decode`: combinational address-to-bank/offset decode plus drop flag. The buffer and FSM stay in the top.

## Test plan
- Lock after reset, SETTLE=4: `clkLocked` rises → `core_reset` stays 1 for 2 sync cycles + 1 + 4, then 0.
- Stream addresses 0x0000, 0x10005, 0x18010, 0x18100 with ack one cycle later → three requests: (0,0x0000), (1,0x0005), (2,0x0010). 0x18100 is dropped with no request.
- Hold `mem_ack` low 5 cycles after a strobe → `ioctl_wait`=1 throughout. A second strobe in that window sets `overrun`=1 and the first byte is preserved.
- Strobe coincident with ack → `mem_req` stays high with the new data; `overrun`=0.
- Index-1 write of 0x03 during RUN → `tno`=0x03, `core_reset` stays 0.
- Assert `reset` in LOAD with `mem_req`=1 → next cycle `mem_req`=0, `core_reset`=1, state LOCKWAIT.
